// File: rtl/led_sequencer.sv
// led_sequencer: debounced push-button front end and mode FSM that sequences
// the 3-bit address and signal input of the 7-output LED demux.
//
// state  | meaning
// -------+------------------------------------------------------------
// MANUAL | step press moves addr one place in dir, wrapping 0<->6
// CHASE  | timer tick moves addr one place in dir, wrapping 0<->6
// BOUNCE | timer tick moves addr, reversing dir at 0 and 6
// OFF    | signal low; addr, dir frozen; timer held at 0
module led_sequencer #(
    parameter int unsigned DEB_CYCLES = 120000,
    parameter int unsigned STEP_DIV   = 1500000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       btn_mode,
    input  logic       btn_step,
    input  logic       btn_dir,
    output logic [2:0] addr,
    output logic       signal,
    output logic [1:0] mode,
    output logic       step_pulse
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned TW = $clog2(STEP_DIV);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(STEP_DIV - 1);

    localparam int BTN_MODE = 0;
    localparam int BTN_STEP = 1;
    localparam int BTN_DIR  = 2;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    logic [2:0]         btn_raw;
    logic [2:0]         sync1_q;
    logic [2:0]         sync2_q;
    logic [2:0]         deb_q;
    logic [2:0]         deb_d;
    logic [2:0]         deb_prev_q;
    logic [2:0]         press_q;
    logic [2:0]         press_d;
    logic [2:0][CW-1:0] deb_cnt_q;
    logic [2:0][CW-1:0] deb_cnt_d;

    logic mode_press;
    logic step_press;
    logic dir_press;

    mode_e mode_q;
    mode_e mode_d;

    logic dir_en;
    logic timer_run;
    logic bounce_mode;
    logic step_src;
    logic step_take;
    logic dir_flip;
    logic dir_tgl;

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [2:0]    addr_q;
    logic [2:0]    addr_d;
    logic          dir_q;
    logic          dir_d;
    logic          step_pulse_q;
    logic          step_pulse_d;
    logic          signal_q;
    logic          signal_d;

    assign btn_raw = {btn_dir, btn_step, btn_mode};

    // Debounce: the accepted level follows the synchronized level only after
    // DEB_CYCLES consecutive disagreeing cycles; any agreement restarts it.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CW'(1);
                end
            end
        end
        press_d = deb_q & ~deb_prev_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            press_q    <= '0;
            deb_cnt_q  <= '0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            press_q    <= press_d;
            deb_cnt_q  <= deb_cnt_d;
        end
    end

    assign mode_press = press_q[BTN_MODE];
    assign step_press = press_q[BTN_STEP];
    assign dir_press  = press_q[BTN_DIR];

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q <= MODE_MANUAL;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (mode_press) begin
            unique case (mode_q)
                MODE_MANUAL: mode_d = MODE_CHASE;
                MODE_CHASE:  mode_d = MODE_BOUNCE;
                MODE_BOUNCE: mode_d = MODE_OFF;
                MODE_OFF:    mode_d = MODE_MANUAL;
            endcase
        end
    end

    always_comb begin
        dir_en      = 1'b0;
        timer_run   = 1'b0;
        bounce_mode = 1'b0;
        step_src    = 1'b0;
        unique case (mode_q)
            MODE_MANUAL: begin
                dir_en   = 1'b1;
                step_src = step_press;
            end
            MODE_CHASE: begin
                dir_en    = 1'b1;
                timer_run = 1'b1;
                step_src  = (timer_q == TIMER_LAST);
            end
            MODE_BOUNCE: begin
                dir_en      = 1'b1;
                timer_run   = 1'b1;
                bounce_mode = 1'b1;
                step_src    = (timer_q == TIMER_LAST);
            end
            MODE_OFF: begin
                dir_en = 1'b0;
            end
        endcase
    end

    // A mode change suppresses any step in the same cycle and restarts the timer.
    always_comb begin
        step_take = step_src & ~mode_press;
        dir_flip  = dir_en & dir_press;
        dir_tgl   = dir_q ^ dir_flip;
        signal_d  = (mode_d != MODE_OFF);

        if (mode_press || !timer_run || (timer_q == TIMER_LAST)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        addr_d       = addr_q;
        dir_d        = dir_tgl;
        step_pulse_d = step_take;
        if (step_take) begin
            // Endpoint reversal is judged on the pre-toggle direction; a dir
            // press arriving together then flips the reversed direction.
            if (bounce_mode && ((addr_q == 3'd6 && !dir_q) || (addr_q == 3'd0 && dir_q))) begin
                addr_d = dir_q ? 3'd1 : 3'd5;
                dir_d  = ~dir_q ^ dir_flip;
            end else if (!dir_tgl) begin
                if (addr_q >= 3'd6) begin
                    addr_d = bounce_mode ? 3'd5 : 3'd0;
                    if (bounce_mode) begin
                        dir_d = 1'b1;
                    end
                end else begin
                    addr_d = addr_q + 3'd1;
                end
            end else begin
                if (addr_q == 3'd0) begin
                    addr_d = bounce_mode ? 3'd1 : 3'd6;
                    if (bounce_mode) begin
                        dir_d = 1'b0;
                    end
                end else if (addr_q == 3'd7) begin
                    addr_d = 3'd6;
                end else begin
                    addr_d = addr_q - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            timer_q      <= '0;
            addr_q       <= 3'd0;
            dir_q        <= 1'b0;
            step_pulse_q <= 1'b0;
            signal_q     <= 1'b1;
        end else begin
            timer_q      <= timer_d;
            addr_q       <= addr_d;
            dir_q        <= dir_d;
            step_pulse_q <= step_pulse_d;
            signal_q     <= signal_d;
        end
    end

    assign addr       = addr_q;
    assign signal     = signal_q;
    assign mode       = mode_q;
    assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with DEB_CYCLES=4, STEP_DIV=10; a press
// raised just after an edge is acted on at the 8th following edge.
module tb_led_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       bm;
    logic       bs;
    logic       bd;
    logic [2:0] addr;
    logic       signal;
    logic [1:0] mode;
    logic       step_pulse;

    int addr_i;
    int mode_i;
    int sig_i;
    int sp_i;

    int checks = 0;
    int errors = 0;
    int pulses;
    int exp_seq [8];

    led_sequencer #(
        .DEB_CYCLES(4),
        .STEP_DIV  (10)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .btn_mode  (bm),
        .btn_step  (bs),
        .btn_dir   (bd),
        .addr      (addr),
        .signal    (signal),
        .mode      (mode),
        .step_pulse(step_pulse)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        addr_i = int'(addr);
        mode_i = int'(mode);
        sig_i  = int'(signal);
        sp_i   = int'(step_pulse);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic cyc_count(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(1);
            if (step_pulse) pulses++;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        exp_seq = '{6, 5, 4, 3, 2, 1, 0, 1};

        // reset with every button held
        RST = 1'b1; bm = 1'b1; bs = 1'b1; bd = 1'b1;
        cyc(3);
        chk("rst_addr", addr_i, 0);
        chk("rst_signal", sig_i, 1);
        chk("rst_mode", mode_i, 0);
        chk("rst_step_pulse", sp_i, 0);
        RST = 1'b0;
        cyc(7);
        chk("rst_mode_c7", mode_i, 0);
        cyc(1);
        chk("rst_mode_c8", mode_i, 1);
        chk("rst_no_step_c8", sp_i, 0);
        chk("rst_addr_c8", addr_i, 0);
        cyc(9);
        chk("rst_chase_c17", addr_i, 0);
        cyc(1);
        // held dir press toggled dir to down along with the mode press
        chk("rst_chase_c18_addr", addr_i, 6);
        chk("rst_chase_c18_pulse", sp_i, 1);
        chk("rst_single_mode_press", mode_i, 1);
        RST = 1'b1; bm = 1'b0; bs = 1'b0; bd = 1'b0;
        cyc(1);
        chk("rst_hold_addr", addr_i, 0);
        chk("rst_hold_mode", mode_i, 0);
        cyc(2);
        RST = 1'b0;
        cyc(2);

        // bounce filtering on btn_step
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) bs = ~bs;
            cyc(1);
            if (step_pulse) pulses++;
        end
        bs = 1'b0;
        cyc_count(6);
        chk("glitch_pulses", pulses, 0);
        chk("glitch_addr", addr_i, 0);
        bs = 1'b1;
        cyc(7);
        chk("press_c7_addr", addr_i, 0);
        cyc(1);
        chk("press_c8_addr", addr_i, 1);
        chk("press_c8_pulse", sp_i, 1);
        cyc(1);
        chk("press_c9_pulse", sp_i, 0);
        bs = 1'b0;
        cyc(6);

        // manual steps up to 6, then chase wrap
        for (int i = 0; i < 5; i++) begin
            bs = 1'b1; cyc(8);
            bs = 1'b0; cyc(7);
        end
        chk("manual_addr6", addr_i, 6);
        bm = 1'b1;
        cyc(8);
        chk("chase_enter_mode", mode_i, 1);
        chk("chase_enter_addr", addr_i, 6);
        bm = 1'b0;
        cyc(9);
        chk("chase_c9_addr", addr_i, 6);
        cyc(1);
        chk("chase_wrap_up", addr_i, 0);
        chk("chase_wrap_pulse", sp_i, 1);
        bd = 1'b1;
        cyc(8);
        bd = 1'b0;
        cyc(2);
        chk("chase_wrap_down", addr_i, 6);
        chk("chase_down_pulse", sp_i, 1);

        // enter bounce at addr 5 with dir toggled back to up
        cyc(3);
        bm = 1'b1; bd = 1'b1;
        cyc(7);
        chk("chase_down_step", addr_i, 5);
        cyc(1);
        chk("bounce_enter_mode", mode_i, 2);
        chk("bounce_enter_addr", addr_i, 5);
        chk("bounce_enter_nopulse", sp_i, 0);
        bm = 1'b0; bd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(10);
            chk($sformatf("bounce_seq%0d", i), addr_i, exp_seq[i]);
            chk($sformatf("bounce_pulse%0d", i), sp_i, 1);
        end

        // OFF mode
        bm = 1'b1;
        cyc(8);
        chk("off_mode", mode_i, 3);
        chk("off_signal", sig_i, 0);
        chk("off_addr", addr_i, 1);
        chk("off_enter_nopulse", sp_i, 0);
        bm = 1'b0;
        pulses = 0;
        cyc_count(7);
        for (int i = 0; i < 3; i++) begin
            bs = 1'b1; bd = 1'b1; cyc_count(8);
            bs = 1'b0; bd = 1'b0; cyc_count(7);
        end
        chk("off_pulses", pulses, 0);
        chk("off_addr_frozen", addr_i, 1);
        chk("off_signal_low", sig_i, 0);
        chk("off_mode_held", mode_i, 3);
        bm = 1'b1;
        cyc(8);
        chk("off_exit_mode", mode_i, 0);
        chk("off_exit_signal", sig_i, 1);
        bm = 1'b0;
        cyc(7);
        bs = 1'b1;
        cyc(8);
        chk("dir_frozen_step", addr_i, 2);
        bs = 1'b0;
        cyc(7);

        // mode press colliding with a chase tick
        bm = 1'b1;
        cyc(8);
        chk("coll_chase_mode", mode_i, 1);
        bm = 1'b0;
        cyc(10);
        chk("coll_first_step", addr_i, 3);
        cyc(2);
        bm = 1'b1;
        cyc(7);
        chk("coll_pre_addr", addr_i, 3);
        cyc(1);
        chk("coll_mode", mode_i, 2);
        chk("coll_addr", addr_i, 3);
        chk("coll_nopulse", sp_i, 0);
        bm = 1'b0;
        cyc(9);
        chk("coll_c9_addr", addr_i, 3);
        cyc(1);
        chk("coll_next_step", addr_i, 4);
        chk("coll_next_pulse", sp_i, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
